// File: rtl/fmv_w_x.sv
// FMV.W.X move unit: low word of rs -> f-register write through a capture stage and a 2-entry FIFO.
// Define FMVWX_NANBOX_EN to NaN-box the upper word; otherwise it is zero-extended.
module fmv_w_x #(
    parameter int DEPTH = 2,
    parameter int TAGW  = 5
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [63:0]     rs,
    input  logic [TAGW-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [63:0]     out_data,
    output logic [TAGW-1:0] out_rd,
    output logic            busy
);

`ifdef FMVWX_NANBOX_EN
    localparam logic [31:0] UPPER = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] UPPER = 32'h0000_0000;
`endif
    localparam logic [1:0] FULL = DEPTH[1:0];

    logic            s1_valid_q, s1_valid_d;
    logic [31:0]     s1_data_q;
    logic [TAGW-1:0] s1_rd_q;
    logic [63:0]     mem_data_q [2];
    logic [TAGW-1:0] mem_rd_q   [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      count_q, count_d;
    logic            pop, s1_adv, accept;
    logic            unused_rs_hi;

    // Both ports transfer on an edge where valid && ready; ready never looks at valid.
    assign pop       = out_valid && out_ready;
    assign s1_adv    = s1_valid_q && ((count_q < FULL) || pop);
    assign in_ready  = EN && (!s1_valid_q || s1_adv);
    assign accept    = in_valid && in_ready;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_data_q[rd_ptr_q];
    assign out_rd    = mem_rd_q[rd_ptr_q];
    assign busy      = s1_valid_q || (count_q != 2'd0);

    assign s1_valid_d   = accept || (s1_valid_q && !s1_adv);
    assign count_d      = count_q + {1'b0, s1_adv} - {1'b0, pop};
    assign unused_rs_hi = ^rs[63:32];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= 32'h0;
            s1_rd_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                mem_data_q[i] <= 64'h0;
                mem_rd_q[i]   <= '0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            count_q    <= count_d;
            if (accept) begin
                s1_data_q <= rs[31:0];
                s1_rd_q   <= in_rd;
            end
            // At count==2 with a pop, wr_ptr equals rd_ptr: the slot being read out is refilled.
            if (s1_adv) begin
                mem_data_q[wr_ptr_q] <= {UPPER, s1_data_q};
                mem_rd_q[wr_ptr_q]   <= s1_rd_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_fmv_w_x.sv
// Directed bench for fmv_w_x: reset, single move, back-pressure, streaming, EN gating, reset mid-operation.
module tb_fmv_w_x;
    logic        CLK, RST, EN, in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0] rs, out_data;
    logic [4:0]  in_rd, out_rd;
    int n_vec = 0;
    int n_fail = 0;

`ifdef FMVWX_NANBOX_EN
    localparam logic [31:0] UP = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] UP = 32'h0000_0000;
`endif

    fmv_w_x #(.DEPTH(2), .TAGW(5)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .in_valid(in_valid), .in_ready(in_ready),
        .rs(rs), .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0; EN = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rs = 64'h0; in_rd = 5'd0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_vec++; if (out_rd !== 5'd0) begin n_fail++; $display("FAIL reset_out_rd got %0d want 0", out_rd); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        next_cycle();
    endtask

    task automatic test_single();
        rs = 64'h1234_5678_C169_6042; in_rd = 5'd3; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge CLK);
        n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready got %b want 1", in_ready); end
        next_cycle();
        in_valid = 1'b0;
        @(negedge CLK);
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy); end
        next_cycle();
        @(negedge CLK);
        n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got %b want 1", out_valid); end
        n_vec++; if (out_data !== {UP, 32'hC169_6042}) begin n_fail++; $display("FAIL single_out_data got %h want %h", out_data, {UP, 32'hC169_6042}); end
        n_vec++; if (out_rd !== 5'd3) begin n_fail++; $display("FAIL single_out_rd got %0d want 3", out_rd); end
        next_cycle();
        @(negedge CLK);
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained_valid got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_drained_busy got %b want 0", busy); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [31:0] pat [4];
        int got;
        bit acc_d;
        pat[0] = 32'hC2CC_BB4A; pat[1] = 32'h423D_0625; pat[2] = 32'hBF48_51EC; pat[3] = 32'h7FC0_0001;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rs = {32'hA5A5_0000 + 32'(i), pat[i]}; in_rd = 5'(10 + i); in_valid = 1'b1;
            @(negedge CLK);
            n_vec++; if (in_ready !== (i < 3)) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want %b", i, in_ready, (i < 3)); end
            if (i < 3) next_cycle();
        end
        next_cycle();
        @(negedge CLK);
        n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
        n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid got %b want 1", out_valid); end
        n_vec++; if (out_data !== {UP, pat[0]}) begin n_fail++; $display("FAIL bp_hold_data got %h want %h", out_data, {UP, pat[0]}); end
        n_vec++; if (out_rd !== 5'd10) begin n_fail++; $display("FAIL bp_hold_rd got %0d want 10", out_rd); end
        next_cycle();
        out_ready = 1'b1;
        got = 0; acc_d = 1'b0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge CLK);
            if (in_valid && in_ready) acc_d = 1'b1;
            if (out_valid) begin
                n_vec++; if (out_data !== {UP, pat[got]}) begin n_fail++; $display("FAIL bp_drain_data[%0d] got %h want %h", got, out_data, {UP, pat[got]}); end
                n_vec++; if (out_rd !== 5'(10 + got)) begin n_fail++; $display("FAIL bp_drain_rd[%0d] got %0d want %0d", got, out_rd, 10 + got); end
                got++;
            end
            next_cycle();
            if (acc_d) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        n_vec++; if (acc_d !== 1'b1) begin n_fail++; $display("FAIL bp_fourth_accepted got %b want 1", acc_d); end
        n_vec++; if (got !== 4) begin n_fail++; $display("FAIL bp_drain_count got %0d want 4", got); end
        repeat (2) next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] pat [8];
        pat[0] = 32'h7F80_0000; pat[1] = 32'hFF80_0000; pat[2] = 32'h0000_0001; pat[3] = 32'h7FC0_0000;
        pat[4] = 32'h8000_0000; pat[5] = 32'h3F80_0000; pat[6] = 32'h7F80_0001; pat[7] = 32'h0000_0000;
        out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                rs = {32'hDEAD_0000 + 32'(c), pat[c]}; in_rd = 5'(20 + c); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge CLK);
            if (c < 8) begin
                n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %b want 1", c, in_ready); end
            end
            if (c >= 2 && c < 10) begin
                n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b want 1", c - 2, out_valid); end
                n_vec++; if (out_data !== {UP, pat[c-2]}) begin n_fail++; $display("FAIL stream_data[%0d] got %h want %h", c - 2, out_data, {UP, pat[c-2]}); end
                n_vec++; if (out_rd !== 5'(18 + c)) begin n_fail++; $display("FAIL stream_rd[%0d] got %0d want %0d", c - 2, out_rd, 18 + c); end
            end
            if (c == 10) begin
                n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid got %b want 0", out_valid); end
            end
            next_cycle();
        end
    endtask

    task automatic test_en_gating();
        out_ready = 1'b0; EN = 1'b1;
        rs = 64'h0000_0000_4049_0FDB; in_rd = 5'd7; in_valid = 1'b1;
        next_cycle();
        EN = 1'b0; rs = 64'h0000_0000_1111_2222; in_rd = 5'd8;
        @(negedge CLK);
        n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL en_in_ready0 got %b want 0", in_ready); end
        next_cycle();
        @(negedge CLK);
        n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL en_in_ready1 got %b want 0", in_ready); end
        n_vec++; if (out_data !== {UP, 32'h4049_0FDB}) begin n_fail++; $display("FAIL en_pending_data got %h want %h", out_data, {UP, 32'h4049_0FDB}); end
        n_vec++; if (out_rd !== 5'd7) begin n_fail++; $display("FAIL en_pending_rd got %0d want 7", out_rd); end
        next_cycle();
        out_ready = 1'b1;
        next_cycle();
        @(negedge CLK);
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL en_drained_valid got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_drained_busy got %b want 0", busy); end
        n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL en_drained_in_ready got %b want 0", in_ready); end
        next_cycle();
        in_valid = 1'b0; EN = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset_midop();
        bit seen;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rs = {32'h0, 32'h3000_0000 + 32'(i)}; in_rd = 5'(i + 1); in_valid = 1'b1;
            next_cycle();
        end
        in_valid = 1'b0;
        next_cycle();
        @(negedge CLK);
        n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before got %b want 1", busy); end
        n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_valid_before got %b want 1", out_valid); end
        next_cycle();
        #1 RST = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_vec++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL rmid_data got %h want 0", out_data); end
        next_cycle();
        RST = 1'b1; out_ready = 1'b1;
        @(negedge CLK);
        n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (out_valid) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmid_ghost_output got %b want 0", seen); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_en_gating();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
